mcu_stripe_scheduler: RTL and testbench

MCU_STRIPE_SCHEDULER -- requirements
Module: mcu_stripe_scheduler

---
 rtl/mcu_stripe_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_mcu_stripe_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_stripe_scheduler.sv
// mcu_stripe_scheduler
//   Feeds one raster stripe of MCUs to NUM_ENG DCT_2D engines, one engine per
//   horizontal MCU, and chains the DC predictor from engine to engine and
//   from the last engine of a stripe to engine 0 of the next stripe.
//
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   start            frame start pulse, ignored while busy
//   num_groups       stripes per frame, latched when start is accepted
//   pix_in/pix_valid raster pixel input; pix_ready high while streaming
//   eng_pix, eng_en  registered pixel broadcast and one-hot engine strobe
//   eng_start        one-cycle pulse coincident with each engine's first pixel
//   eng_first        high while stripe 0 of a frame is in progress
//   eng_valid        engine output-valid levels (rising edge = result ready)
//   eng_dc_out       engine DC results, engine k at [k*DC_W +: DC_W]
//   eng_dc_in        DC predictor presented to each engine
//   busy, done       frame in progress / one-cycle frame-complete pulse
//   stripe_idx       current stripe number
module mcu_stripe_scheduler #(
  parameter int NUM_ENG = 8,
  parameter int PIX_W   = 8,
  parameter int DC_W    = 14,
  parameter int ROW_LEN = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [15:0]             num_groups,
  input  logic [PIX_W-1:0]        pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  output logic [PIX_W-1:0]        eng_pix,
  output logic [NUM_ENG-1:0]      eng_en,
  output logic [NUM_ENG-1:0]      eng_start,
  output logic                    eng_first,
  input  logic [NUM_ENG-1:0]      eng_valid,
  input  logic [NUM_ENG*DC_W-1:0] eng_dc_out,
  output logic [NUM_ENG*DC_W-1:0] eng_dc_in,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             stripe_idx
);

  localparam int CW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int EW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(ROW_LEN - 1);
  localparam logic [EW-1:0] ENG_MAX = EW'(NUM_ENG - 1);

  typedef enum logic [2:0] {IDLE, STREAM, WAIT_ENG, DRAIN, DONE} state_t;

  state_t             state_q;
  logic [15:0]        ng_q;
  logic [15:0]        stripe_q;
  logic [CW-1:0]      col_q;
  logic [CW-1:0]      row_q;
  logic [EW-1:0]      eng_q;
  logic [PIX_W-1:0]   pix_q;
  logic [NUM_ENG-1:0] en_q;
  logic [NUM_ENG-1:0] start_q;
  logic [NUM_ENG-1:0] vprev_q;
  logic [NUM_ENG-1:0] seen_q;
  logic [DC_W-1:0]    dc_q [NUM_ENG];

  logic               accept;
  logic               last_beat;
  logic               last_stripe;
  logic               recording;
  logic               all_seen;
  logic [NUM_ENG-1:0] rise;
  logic [NUM_ENG-1:0] eng_onehot;

  assign accept      = pix_valid && (state_q == STREAM);
  assign last_beat   = accept && (col_q == COL_MAX) && (eng_q == ENG_MAX) && (row_q == COL_MAX);
  assign last_stripe = (stripe_q == (ng_q - 16'd1));
  assign rise        = eng_valid & ~vprev_q;
  // Engine completions are only meaningful while a frame is active.
  assign recording   = (state_q == STREAM) || (state_q == WAIT_ENG) || (state_q == DRAIN);
  assign all_seen    = &seen_q;
  assign eng_onehot  = NUM_ENG'(1) << eng_q;

  assign pix_ready  = (state_q == STREAM);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign eng_first  = busy && (stripe_q == 16'd0);
  assign eng_pix    = pix_q;
  assign eng_en     = en_q;
  assign eng_start  = start_q;
  assign stripe_idx = stripe_q;

  // Engine k predicts from engine k-1 of the same stripe; engine 0 predicts
  // from the last engine of the previous stripe, or from zero on stripe 0.
  always_comb begin
    eng_dc_in = '0;
    for (int unsigned k = 1; k < NUM_ENG; k++) begin
      eng_dc_in[k*DC_W +: DC_W] = dc_q[k-1];
    end
    eng_dc_in[DC_W-1:0] = (stripe_q == 16'd0) ? '0 : dc_q[NUM_ENG-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ng_q     <= '0;
      stripe_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      eng_q    <= '0;
      pix_q    <= '0;
      en_q     <= '0;
      start_q  <= '0;
      vprev_q  <= '0;
      seen_q   <= '0;
      for (int unsigned k = 0; k < NUM_ENG; k++) begin
        dc_q[k] <= '0;
      end
    end else begin
      vprev_q <= eng_valid;
      en_q    <= '0;
      start_q <= '0;

      if (recording) begin
        seen_q <= seen_q | rise;
        for (int unsigned k = 0; k < NUM_ENG; k++) begin
          if (rise[k]) dc_q[k] <= eng_dc_out[k*DC_W +: DC_W];
        end
      end

      if (accept) begin
        pix_q <= pix_in;
        en_q  <= eng_onehot;
        if ((row_q == '0) && (col_q == '0)) start_q <= eng_onehot;
        if (col_q == COL_MAX) begin
          col_q <= '0;
          if (eng_q == ENG_MAX) begin
            eng_q <= '0;
            row_q <= (row_q == COL_MAX) ? '0 : row_q + 1'b1;
          end else begin
            eng_q <= eng_q + 1'b1;
          end
        end else begin
          col_q <= col_q + 1'b1;
        end
      end

      // State-specific updates come last so the WAIT_ENG exit clear of
      // seen_q overrides the recording update above.
      case (state_q)
        IDLE: begin
          if (start) begin
            ng_q     <= num_groups;
            stripe_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            eng_q    <= '0;
            seen_q   <= '0;
            for (int unsigned k = 0; k < NUM_ENG; k++) begin
              dc_q[k] <= '0;
            end
            state_q <= (num_groups == 16'd0) ? DONE : STREAM;
          end
        end
        STREAM: begin
          if (last_beat) state_q <= last_stripe ? DRAIN : WAIT_ENG;
        end
        WAIT_ENG: begin
          if (all_seen) begin
            seen_q   <= '0;
            stripe_q <= stripe_q + 16'd1;
            state_q  <= STREAM;
          end
        end
        DRAIN: begin
          if (all_seen) state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_stripe_scheduler.sv
// Self-checking bench for mcu_stripe_scheduler: random pixels and random
// engine latencies/results, checked against a beat-index reference model.
module tb_mcu_stripe_scheduler;

  localparam int NE = 8;
  localparam int PW = 8;
  localparam int DW = 14;
  localparam int RL = 8;
  localparam int SL = RL * RL * NE;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [15:0]       num_groups;
  logic [PW-1:0]     pix_in;
  logic              pix_valid;
  logic              pix_ready;
  logic [PW-1:0]     eng_pix;
  logic [NE-1:0]     eng_en;
  logic [NE-1:0]     eng_start;
  logic              eng_first;
  logic [NE-1:0]     eng_valid;
  logic [NE*DW-1:0]  eng_dc_out;
  logic [NE*DW-1:0]  eng_dc_in;
  logic              busy;
  logic              done;
  logic [15:0]       stripe_idx;

  mcu_stripe_scheduler #(.NUM_ENG(NE), .PIX_W(PW), .DC_W(DW), .ROW_LEN(RL)) dut (
    .clk(clk), .rst(rst), .start(start), .num_groups(num_groups),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .eng_pix(eng_pix), .eng_en(eng_en), .eng_start(eng_start),
    .eng_first(eng_first), .eng_valid(eng_valid), .eng_dc_out(eng_dc_out),
    .eng_dc_in(eng_dc_in), .busy(busy), .done(done), .stripe_idx(stripe_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Controls written only by the main sequence.
  int  vmode = 0;          // 0 idle, 1 always valid, 2 toggle, 3 random
  bit  clr = 1'b0;
  bit  dc_fixed = 1'b0;
  int  dly [NE];

  // Pixel source: records what the DUT will accept at the coming edge.
  logic [PW-1:0] sent [$];
  always @(negedge clk) begin
    case (vmode)
      0:       pix_valid = 1'b0;
      1:       pix_valid = 1'b1;
      2:       pix_valid = ((cyc % 2) == 0);
      default: pix_valid = ($urandom_range(0, 9) < 7);
    endcase
    pix_in = PW'($urandom);
    if (clr) sent.delete();
    else if (!rst && pix_valid && pix_ready) sent.push_back(pix_in);
  end

  // Output monitor.
  logic [PW-1:0]    got_pix [$];
  logic [NE-1:0]    got_en [$];
  logic [NE-1:0]    got_st [$];
  int               got_cyc [$];
  int               done_cyc [$];
  int               rdy_rise [$];
  logic [NE*DW-1:0] snap [$];
  logic             snap_first [$];
  int               snap_idx [$];
  int               stray = 0;
  logic             rdy_prev = 1'b0;
  logic [15:0]      sidx_prev = '0;
  always @(negedge clk) begin
    if (clr) begin
      got_pix.delete(); got_en.delete(); got_st.delete(); got_cyc.delete();
      done_cyc.delete(); rdy_rise.delete(); snap.delete(); snap_first.delete();
      snap_idx.delete(); stray = 0;
    end
    if (rst) begin
      rdy_prev = 1'b0;
      sidx_prev = '0;
    end else if (!clr) begin
      if (eng_en != '0) begin
        got_pix.push_back(eng_pix); got_en.push_back(eng_en);
        got_st.push_back(eng_start); got_cyc.push_back(cyc);
      end else if (eng_start != '0) begin
        stray++;
      end
      if (done) done_cyc.push_back(cyc);
      if (pix_ready && !rdy_prev) rdy_rise.push_back(cyc);
      rdy_prev = pix_ready;
      if (busy && stripe_idx != sidx_prev) begin
        snap.push_back(eng_dc_in); snap_first.push_back(eng_first);
        snap_idx.push_back(int'(stripe_idx));
      end
      sidx_prev = stripe_idx;
    end
  end

  // Engine model: each engine raises eng_valid dly[k] cycles after its 64th
  // pixel strobe and holds it until its next eng_start.
  int            tmr [NE];
  int            cnt [NE];
  int            es [NE];
  logic [DW-1:0] dc_hist [4][NE];
  int            ev_hist [4][NE];
  always @(negedge clk) begin
    if (rst || done) begin
      if (rst) begin
        eng_valid = '0;
        eng_dc_out = '0;
      end
      for (int k = 0; k < NE; k++) begin
        tmr[k] = 0; cnt[k] = 0; es[k] = -1;
      end
    end else begin
      for (int k = 0; k < NE; k++) begin
        if (eng_start[k]) begin
          eng_valid[k] = 1'b0; cnt[k] = 0; es[k]++;
        end
        if (tmr[k] > 0) begin
          tmr[k]--;
          if (tmr[k] == 0 && es[k] >= 0 && es[k] < 4) begin
            dc_hist[es[k]][k] = (dc_fixed && es[k] == 0) ? DW'(100 + k) : DW'($urandom);
            ev_hist[es[k]][k] = cyc;
            eng_dc_out[k*DW +: DW] = dc_hist[es[k]][k];
            eng_valid[k] = 1'b1;
          end
        end
        if (eng_en[k]) begin
          cnt[k]++;
          if (cnt[k] == RL * RL) tmr[k] = dly[k];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic go(input logic [15:0] ng);
    start = 1'b1;
    num_groups = ng;
    tick();
    start = 1'b0;
    num_groups = 16'hFFFF;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int t = 0;
    while (done_cyc.size() == 0 && t < budget) begin
      tick();
      t++;
    end
    check({tag, "_done_seen"}, 64'(done_cyc.size() != 0), 64'd1);
    tick();
    tick();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_outs"}, {pix_ready, eng_en, eng_start, eng_first, busy, done, eng_pix, stripe_idx}, '0);
    check({tag, "_dcin"}, 64'(|eng_dc_in), 64'd0);
  endtask

  task automatic check_stream(input string tag, input int nstr);
    check({tag, "_beats"}, got_pix.size(), nstr * SL);
    check({tag, "_sent"}, sent.size(), nstr * SL);
    check({tag, "_stray_start"}, stray, 0);
    for (int i = 0; i < got_pix.size() && i < sent.size(); i++) begin
      int n = i % SL;
      logic [NE-1:0] een = NE'(1) << ((n / RL) % NE);
      logic [NE-1:0] est = (n < RL * NE && n % RL == 0) ? een : '0;
      check($sformatf("%s_beat%0d", tag, i), {got_st[i], got_en[i], got_pix[i]}, {est, een, sent[i]});
    end
  endtask

  task automatic check_snap(input string tag, input int s);
    int found = -1;
    logic [NE*DW-1:0] v;
    for (int i = 0; i < snap_idx.size(); i++) begin
      if (found < 0 && snap_idx[i] == s) found = i;
    end
    check($sformatf("%s_snap%0d_found", tag, s), 64'(found >= 0), 64'd1);
    if (found >= 0) begin
      v = snap[found];
      check($sformatf("%s_snap%0d_first", tag, s), snap_first[found], 0);
      for (int k = 0; k < NE; k++) begin
        check($sformatf("%s_snap%0d_dcin%0d", tag, s, k), v[k*DW +: DW],
              (k == 0) ? dc_hist[s-1][NE-1] : dc_hist[s-1][k-1]);
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NE*DW-1:0] v;
    int t;
    rst = 1'b1; start = 1'b0; num_groups = '0;
    for (int k = 0; k < NE; k++) dly[k] = 20;
    tick(); tick();
    check_zero_outputs("reset");
    clear_logs();
    rst = 1'b0;

    // Single stripe, continuous valid.
    vmode = 1;
    go(16'd1);
    check("t1_busy", busy, 1);
    check("t1_first", eng_first, 1);
    wait_done("t1", 3000);
    vmode = 0;
    check_stream("t1", 1);
    check("t1_done_count", done_cyc.size(), 1);
    if (done_cyc.size() > 0) check("t1_done_lat", done_cyc[0] - ev_hist[0][NE-1], 2);
    check("t1_idle", {busy, pix_ready}, 2'b00);

    // DC chain across two stripes, fixed stripe-0 results 100+k.
    dc_fixed = 1'b1;
    clear_logs();
    vmode = 1;
    go(16'd2);
    repeat (100) tick();
    check("t2_s0_dcin0", eng_dc_in[DW-1:0], 0);
    check("t2_s0_first", eng_first, 1);
    wait_done("t2", 5000);
    vmode = 0;
    check_stream("t2", 2);
    check_snap("t2", 1);
    for (int i = 0; i < snap_idx.size(); i++) begin
      if (snap_idx[i] == 1) begin
        v = snap[i];
        check("t2_s1_dcin0", v[DW-1:0], 107);
        check("t2_s1_dcin3", v[3*DW +: DW], 102);
      end
    end
    dc_fixed = 1'b0;

    // Backpressure: valid toggles every cycle.
    clear_logs();
    vmode = 2;
    go(16'd1);
    wait_done("t3", 5000);
    vmode = 0;
    check_stream("t3", 1);
    if (got_cyc.size() == SL) check("t3_span", got_cyc[SL-1] - got_cyc[0], 2 * (SL - 1));

    // WAIT_ENG hold: engine 5 is slow.
    dly[5] = 300;
    clear_logs();
    vmode = 1;
    go(16'd2);
    wait_done("t4", 6000);
    vmode = 0;
    check_stream("t4", 2);
    check("t4_ready_rises", rdy_rise.size(), 2);
    if (rdy_rise.size() >= 2) check("t4_resume", rdy_rise[1] - ev_hist[0][5], 2);
    if (got_cyc.size() > SL && rdy_rise.size() >= 2) check("t4_s1_first_strobe", got_cyc[SL] - rdy_rise[1], 1);
    check_snap("t4", 1);
    dly[5] = 20;

    // Reset mid-stripe, then an immediate restart.
    clear_logs();
    vmode = 3;
    go(16'd1);
    t = 0;
    while (got_pix.size() < 200 && t < 2000) begin
      tick();
      t++;
    end
    check("t5_reach200", 64'(got_pix.size() >= 200), 64'd1);
    rst = 1'b1;
    #1;
    check_zero_outputs("t5_rst");
    check("t5_no_done", done_cyc.size(), 0);
    vmode = 1;
    clear_logs();
    rst = 1'b0;
    go(16'd1);
    check("t5_restart_busy", busy, 1);
    wait_done("t5", 3000);
    vmode = 0;
    check_stream("t5", 1);
    check("t5_done_count", done_cyc.size(), 1);

    // Zero groups.
    clear_logs();
    start = 1'b1; num_groups = 16'd0;
    tick();
    start = 1'b0;
    check("t6_done_hi", {done, busy, pix_ready}, 3'b110);
    tick();
    check("t6_done_lo", {done, busy}, 2'b00);
    tick();
    check("t6_no_strobes", got_pix.size(), 0);
    check("t6_no_start", stray, 0);
    check("t6_done_count", done_cyc.size(), 1);

    // Random: three stripes, random valid, latencies and results; a start
    // pulse mid-frame must be ignored.
    for (int k = 0; k < NE; k++) dly[k] = $urandom_range(1, 60);
    clear_logs();
    vmode = 3;
    go(16'd3);
    t = 0;
    while (got_pix.size() < 300 && t < 2000) begin
      tick();
      t++;
    end
    start = 1'b1; num_groups = 16'd1;
    tick();
    start = 1'b0;
    wait_done("t7", 20000);
    vmode = 0;
    check_stream("t7", 3);
    check("t7_done_count", done_cyc.size(), 1);
    check_snap("t7", 1);
    check_snap("t7", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
